// File: rtl/operand_entry_pkg.sv
// Shared definitions for the decimal operand entry block.
//   state_e            : conversion controller states
//   BcdWidth, MaxDigit : BCD digit geometry
//   SatValue           : value presented when a conversion exceeds 16 bits
//   Autorepeat*        : hold timing for the optional Inc autorepeat
//                        (OPERAND_ENTRY_AUTOREPEAT_EN)
package operand_entry_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StConvert = 2'd1,
    StDone    = 2'd2
  } state_e;

  localparam int unsigned BcdWidth = 4;
  localparam logic [BcdWidth-1:0] MaxDigit = 4'd9;
  localparam logic [15:0] SatValue = 16'hFFFF;

  localparam int unsigned AutorepeatDelayMs  = 500;
  localparam int unsigned AutorepeatPeriodMs = 200;

  // Decimal increment of a single BCD digit, 9 wraps to 0.
  function automatic logic [BcdWidth-1:0] bcd_inc(input logic [BcdWidth-1:0] d);
    return (d >= MaxDigit) ? '0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/operand_entry_key_debounce.sv
// key_debounce: conditions one raw active-low push button.
//   clk, rst_n    : clock, asynchronous active-low reset
//   one_ms_pulse  : one-cycle tick per millisecond
//   key_n         : raw asynchronous button, active-low
//   stable        : debounced level, 1 = released
//   press         : one-cycle pulse when the debounced level goes 1 -> 0
module key_debounce #(
  parameter int unsigned DEBOUNCE_MS = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic one_ms_pulse,
  input  logic key_n,
  output logic stable,
  output logic press
);

  localparam logic [7:0] CntLast = 8'(DEBOUNCE_MS - 1);

  logic       sync1_q, sync2_q;
  logic       stable_q, stable_d;
  logic       prev_q;
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (one_ms_pulse) begin
      if (cnt_q == CntLast) begin
        stable_d = sync2_q;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      prev_q   <= 1'b1;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= key_n;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      prev_q   <= stable_q;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;
  assign press  = prev_q & ~stable_q;

endmodule

// File: rtl/operand_entry.sv
// operand_entry: front-panel decimal operand entry.
// Three debounced keys edit NUM_DIGITS BCD digits; Enter converts them to
// binary one digit per cycle (acc*10 + digit) and reports a saturated 16-bit
// result with a one-cycle valid pulse.
//   clk, rst_n     : clock, asynchronous active-low reset
//   oneMsPulse     : one-cycle tick per millisecond (debounce/autorepeat timing)
//   KeyDigit_n     : raw key, moves the cursor
//   KeyInc_n       : raw key, increments the digit under the cursor
//   KeyEnter_n     : raw key, starts a conversion
//   EntryDigits    : BCD digits, [3:0] least significant
//   CursorPos      : selected digit index, 0 = least significant
//   EntryValue     : last converted value (saturated to 16'hFFFF)
//   EntryValid     : one-cycle pulse when EntryValue/EntryOverflow update
//   EntryOverflow  : last conversion exceeded 65535
//   Busy           : conversion in progress
// Build option: define OPERAND_ENTRY_AUTOREPEAT_EN to add hold-to-repeat on Inc.
module operand_entry
  import operand_entry_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 5,
  parameter int unsigned DEBOUNCE_MS = 20
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           oneMsPulse,
  input  logic                           KeyDigit_n,
  input  logic                           KeyInc_n,
  input  logic                           KeyEnter_n,
  output logic [BcdWidth*NUM_DIGITS-1:0] EntryDigits,
  output logic [2:0]                     CursorPos,
  output logic [15:0]                    EntryValue,
  output logic                           EntryValid,
  output logic                           EntryOverflow,
  output logic                           Busy
);

  localparam logic [2:0] LastIdx = 3'(NUM_DIGITS - 1);

  // Key conditioning
  logic digit_stable, digit_press;
  logic inc_stable, inc_press;
  logic enter_stable, enter_press;

  key_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_key_digit (
    .clk          (clk),
    .rst_n        (rst_n),
    .one_ms_pulse (oneMsPulse),
    .key_n        (KeyDigit_n),
    .stable       (digit_stable),
    .press        (digit_press)
  );

  key_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_key_inc (
    .clk          (clk),
    .rst_n        (rst_n),
    .one_ms_pulse (oneMsPulse),
    .key_n        (KeyInc_n),
    .stable       (inc_stable),
    .press        (inc_press)
  );

  key_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_key_enter (
    .clk          (clk),
    .rst_n        (rst_n),
    .one_ms_pulse (oneMsPulse),
    .key_n        (KeyEnter_n),
    .stable       (enter_stable),
    .press        (enter_press)
  );

  // Only the Inc level has a consumer, and only with autorepeat.
  logic unused_stable;
  assign unused_stable = digit_stable ^ enter_stable;

  logic inc_event;

`ifdef OPERAND_ENTRY_AUTOREPEAT_EN
  localparam logic [9:0] HoldFire   = 10'(AutorepeatDelayMs - 1);
  // Reloading after each repeat makes the next one land a full period later.
  localparam logic [9:0] HoldReload = 10'(AutorepeatDelayMs - AutorepeatPeriodMs);

  logic [9:0] hold_q, hold_d;
  logic       repeat_event;

  always_comb begin
    hold_d       = hold_q;
    repeat_event = 1'b0;
    if (inc_stable) begin
      hold_d = '0;
    end else if (oneMsPulse) begin
      if (hold_q == HoldFire) begin
        repeat_event = 1'b1;
        hold_d       = HoldReload;
      end else begin
        hold_d = hold_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end

  assign inc_event = inc_press | repeat_event;
`else
  logic unused_inc_stable;
  assign unused_inc_stable = inc_stable;
  assign inc_event = inc_press;
`endif

  // Conversion controller
  state_e                                  state_q, state_d;
  logic [19:0]                             acc_q, acc_d, acc_next;
  logic [2:0]                              idx_q, idx_d;
  logic [NUM_DIGITS-1:0][BcdWidth-1:0]     digits_q, digits_d;
  logic [2:0]                              cursor_q, cursor_d;
  logic [15:0]                             value_q, value_d;
  logic                                    ovf_q, ovf_d;
  logic                                    valid_q, valid_d;
  logic                                    busy_q, busy_d;

  assign acc_next = (acc_q << 3) + (acc_q << 1) + 20'(digits_q[idx_q]);

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    digits_d = digits_q;
    cursor_d = cursor_q;
    value_d  = value_q;
    ovf_d    = ovf_q;
    valid_d  = 1'b0;
    busy_d   = busy_q;

    unique case (state_q)
      StIdle: begin
        if (enter_press) begin
          state_d = StConvert;
          acc_d   = '0;
          idx_d   = LastIdx;
          busy_d  = 1'b1;
        end else if (inc_event) begin
          digits_d[cursor_q] = bcd_inc(digits_q[cursor_q]);
        end else if (digit_press) begin
          cursor_d = (cursor_q == LastIdx) ? 3'd0 : cursor_q + 3'd1;
        end
      end
      StConvert: begin
        acc_d = acc_next;
        idx_d = idx_q - 3'd1;
        if (idx_q == 3'd0) begin
          // Result registers load on entry to DONE so that the valid pulse
          // and the saturated value are visible during the DONE cycle itself.
          state_d = StDone;
          valid_d = 1'b1;
          if (acc_next > {4'b0, SatValue}) begin
            value_d = SatValue;
            ovf_d   = 1'b1;
          end else begin
            value_d = acc_next[15:0];
            ovf_d   = 1'b0;
          end
        end
      end
      StDone: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      idx_q    <= '0;
      digits_q <= '0;
      cursor_q <= '0;
      value_q  <= '0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      digits_q <= digits_d;
      cursor_q <= cursor_d;
      value_q  <= value_d;
      ovf_q    <= ovf_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  assign EntryDigits   = digits_q;
  assign CursorPos     = cursor_q;
  assign EntryValue    = value_q;
  assign EntryValid    = valid_q;
  assign EntryOverflow = ovf_q;
  assign Busy          = busy_q;

endmodule
